// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with fill count, threshold flags, sticky
// error flags and selectable registered / first-word-fall-through read port.
module sync_fifo #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [DATASIZE-1:0] wr_data,
  output logic                wr_full,
  output logic                wr_afull,
  output logic                wr_ack,
  output logic                overflow,
  input  logic                rd_en,
  output logic [DATASIZE-1:0] rd_data,
  output logic                rd_empty,
  output logic                rd_aempty,
  output logic                rd_ack,
  output logic                underflow,
  output logic [ADDRSIZE:0]   count,
  input  logic                clr_err
);

  localparam int              DEPTH     = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C   = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_C   = (ADDRSIZE+1)'(AFULL_TH);
  localparam logic [ADDRSIZE:0] AEMPTY_C  = (ADDRSIZE+1)'(AEMPTY_TH);
  localparam logic [ADDRSIZE:0] ONE_C     = (ADDRSIZE+1)'(1);

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRSIZE:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRSIZE:0] count_q, count_d;
  logic              wr_full_q, wr_full_d;
  logic              wr_afull_q, wr_afull_d;
  logic              rd_empty_q, rd_empty_d;
  logic              rd_aempty_q, rd_aempty_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic                wr_acc, rd_acc;
  logic [ADDRSIZE-1:0] wr_addr, rd_addr;

  assign wr_addr = wr_ptr_q[ADDRSIZE-1:0];
  assign rd_addr = rd_ptr_q[ADDRSIZE-1:0];

  always_comb begin
    wr_acc = wr_en & ~wr_full_q;
    rd_acc = rd_en & ~rd_empty_q;

    wr_ptr_d = wr_acc ? wr_ptr_q + ONE_C : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ONE_C : rd_ptr_q;

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // Flags derive from the next count so they always agree with count.
    wr_full_d   = (count_d == DEPTH_C);
    wr_afull_d  = (count_d >= AFULL_C);
    rd_empty_d  = (count_d == '0);
    rd_aempty_d = (count_d <= AEMPTY_C);

    wr_ack_d = wr_acc;
    rd_ack_d = rd_acc;

    // Set condition takes priority over clr_err.
    overflow_d  = (wr_en & wr_full_q)  | (overflow_q  & ~clr_err);
    underflow_d = (rd_en & rd_empty_q) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_full_q   <= 1'b0;
      wr_afull_q  <= (AFULL_TH == 0);
      rd_empty_q  <= 1'b1;
      rd_aempty_q <= 1'b1;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_full_q   <= wr_full_d;
      wr_afull_q  <= wr_afull_d;
      rd_empty_q  <= rd_empty_d;
      rd_aempty_q <= rd_aempty_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; forced to zero while empty so the
      // port reads 0 out of reset rather than uninitialised storage.
      assign rd_data = rd_empty_q ? '0 : mem[rd_addr];
    end else begin : g_reg
      logic [DATASIZE-1:0] rd_data_q, rd_data_d;

      always_comb begin
        rd_data_d = rd_acc ? mem[rd_addr] : rd_data_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q <= '0;
        end else begin
          rd_data_q <= rd_data_d;
        end
      end

      assign rd_data = rd_data_q;
    end
  endgenerate

  assign wr_full   = wr_full_q;
  assign wr_afull  = wr_afull_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign rd_empty  = rd_empty_q;
  assign rd_aempty = rd_aempty_q;
  assign rd_ack    = rd_ack_q;
  assign underflow = underflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-read instance checked every cycle
// against a queue model, plus a first-word-fall-through instance.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_full, wr_afull, wr_ack, overflow;
  logic       rd_empty, rd_aempty, rd_ack, underflow;
  logic [7:0] rd_data;
  logic [4:0] count;

  logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
  logic [7:0] f_wr_data = '0;
  logic       f_wr_full, f_wr_afull, f_wr_ack, f_overflow;
  logic       f_rd_empty, f_rd_aempty, f_rd_ack, f_underflow;
  logic [7:0] f_rd_data;
  logic [4:0] f_count;

  int unsigned passes = 0;
  int unsigned fails  = 0;
  int unsigned total  = 0;

  // Reference model state
  int         m_cnt = 0;
  logic       ovf_m = 1'b0, unf_m = 1'b0;
  logic [7:0] last_rd = '0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sync_fifo #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_afull(wr_afull),
    .wr_ack(wr_ack), .overflow(overflow),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_aempty(rd_aempty),
    .rd_ack(rd_ack), .underflow(underflow), .count(count), .clr_err(clr_err)
  );

  sync_fifo #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_full(f_wr_full), .wr_afull(f_wr_afull),
    .wr_ack(f_wr_ack), .overflow(f_overflow),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_empty(f_rd_empty), .rd_aempty(f_rd_aempty),
    .rd_ack(f_rd_ack), .underflow(f_underflow), .count(f_count), .clr_err(f_clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of the registered-read instance, model update and full check.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    logic       wacc, racc;
    logic [7:0] exp_rd;
    wr_en = we; wr_data = wd; rd_en = re; clr_err = clr;
    @(posedge clk);
    wacc = we && (m_cnt != 16);
    racc = re && (m_cnt != 0);
    if (we && m_cnt == 16) ovf_m = 1'b1; else if (clr) ovf_m = 1'b0;
    if (re && m_cnt == 0)  unf_m = 1'b1; else if (clr) unf_m = 1'b0;
    exp_rd = last_rd;
    if (racc) exp_rd = exp_q.pop_front();
    if (wacc) exp_q.push_back(wd);
    m_cnt = m_cnt + int'(wacc) - int'(racc);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    chk("count",     32'(count),     32'(m_cnt));
    chk("wr_full",   32'(wr_full),   32'(m_cnt == 16));
    chk("wr_afull",  32'(wr_afull),  32'(m_cnt >= 12));
    chk("rd_empty",  32'(rd_empty),  32'(m_cnt == 0));
    chk("rd_aempty", 32'(rd_aempty), 32'(m_cnt <= 2));
    chk("wr_ack",    32'(wr_ack),    32'(wacc));
    chk("rd_ack",    32'(rd_ack),    32'(racc));
    chk("overflow",  32'(overflow),  32'(ovf_m));
    chk("underflow", 32'(underflow), 32'(unf_m));
    chk("rd_data",   32'(rd_data),   32'(exp_rd));
    last_rd = exp_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned written;
    // Reset
    #2 rst_n = 1'b0;
    #3;
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_empty",     32'(rd_empty),  32'd1);
    chk("rst_aempty",    32'(rd_aempty), 32'd1);
    chk("rst_full",      32'(wr_full),   32'd0);
    chk("rst_afull",     32'(wr_afull),  32'd0);
    chk("rst_ovf",       32'(overflow),  32'd0);
    chk("rst_unf",       32'(underflow), 32'd0);
    chk("rst_wr_ack",    32'(wr_ack),    32'd0);
    chk("rst_rd_ack",    32'(rd_ack),    32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'd0);
    chk("rst_f_rd_data", 32'(f_rd_data), 32'd0);
    chk("rst_f_empty",   32'(f_rd_empty), 32'd1);
    #7 rst_n = 1'b1;

    // Fill to full, then one rejected write
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);

    // Drain in order, then one rejected read
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous at full, then at empty
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // clr_err against a simultaneous overflow, then alone
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hDD, 1'b0, 1'b0);
    cyc(1'b1, 8'hDD, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around stream of 40 words with count held in 3..10
    written = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'(8'h40 + written), 1'b0, 1'b0);
      written++;
    end
    for (int k = 0; k < 400 && written < 40; k++) begin
      logic we, re;
      we = (m_cnt < 10) && ($urandom_range(0, 3) != 0);
      re = (m_cnt > 3)  && ($urandom_range(0, 1) != 0);
      cyc(we, 8'(8'h40 + written), re, 1'b0);
      if (we) written++;
    end
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // First-word-fall-through instance
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    chk("fwft_data",  32'(f_rd_data),  32'hA5);
    chk("fwft_empty", 32'(f_rd_empty), 32'd0);
    chk("fwft_count", 32'(f_count),    32'd1);
    chk("fwft_ack0",  32'(f_rd_ack),   32'd0);
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    chk("fwft_pop_empty", 32'(f_rd_empty), 32'd1);
    chk("fwft_pop_ack",   32'(f_rd_ack),   32'd1);
    @(posedge clk); #1;
    chk("fwft_ack_pulse", 32'(f_rd_ack),   32'd0);
    f_wr_en = 1'b1; f_wr_data = 8'h11;
    @(posedge clk); #1;
    f_wr_data = 8'h22;
    @(posedge clk); #1;
    f_wr_en = 1'b0; f_rd_en = 1'b1;
    chk("fwft_head1", 32'(f_rd_data), 32'h11);
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    chk("fwft_head2", 32'(f_rd_data), 32'h22);
    chk("fwft_cnt2",  32'(f_count),   32'd1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count),    32'd0);
    chk("async_rst_empty", 32'(rd_empty), 32'd1);
    chk("async_rst_f_cnt", 32'(f_count),  32'd0);
    m_cnt = 0; ovf_m = 1'b0; unf_m = 1'b0; last_rd = '0; exp_q.delete();
    wr_en = 1'b1; wr_data = 8'h99;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("rst_hold_count", 32'(count), 32'd0);
    #2 rst_n = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
